// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_prog
//  Brief    : Multi-channel runtime-programmable clock divider. Each channel
//             produces a registered divided waveform with programmable period
//             and high time plus a one-cycle period-start tick. New settings
//             are written through a valid/ready handshake into a shadow
//             register and take effect glitch-free at the next period
//             boundary.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 8,
    parameter int RESET_DIV  = 16,
    parameter int RESET_HIGH = 8,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sync,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [CNT_WIDTH-1:0] cfg_div,
    input  logic [CNT_WIDTH-1:0] cfg_high,
    output logic [NUM_CH-1:0]    clk_out,
    output logic [NUM_CH-1:0]    tick
);

    localparam logic [CNT_WIDTH-1:0] c_reset_div  = CNT_WIDTH'(RESET_DIV);
    localparam logic [CNT_WIDTH-1:0] c_reset_high = CNT_WIDTH'(RESET_HIGH);
    localparam logic [CNT_WIDTH-1:0] c_one        = CNT_WIDTH'(1);
    localparam logic                 c_reset_clk  = (RESET_HIGH != 0);

    logic [NUM_CH-1:0] w_pending;
    logic              w_ch_ok;
    logic              w_accept;

    // Handshake: a channel accepts a new setting only while nothing is queued
    // for it; writes to non-existent channels are acknowledged and discarded.
    always_comb begin
        w_ch_ok   = (32'(cfg_ch) < 32'(NUM_CH));
        cfg_ready = w_ch_ok ? !w_pending[cfg_ch] : 1'b1;
        w_accept  = cfg_valid && cfg_ready && w_ch_ok;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_WIDTH-1:0] r_cnt;
        logic [CNT_WIDTH-1:0] r_div_act;
        logic [CNT_WIDTH-1:0] r_high_act;
        logic [CNT_WIDTH-1:0] r_div_shd;
        logic [CNT_WIDTH-1:0] r_high_shd;
        logic                 r_pending;
        logic                 r_clk_out;
        logic                 r_tick;

        logic                 w_wr;
        logic                 w_stopped;
        logic                 w_wrap;
        logic                 w_apply;
        logic                 w_live;
        logic [CNT_WIDTH-1:0] w_cnt_nxt;
        logic [CNT_WIDTH-1:0] w_div_new;
        logic [CNT_WIDTH-1:0] w_high_new;

        // Next phase and boundary detection; a stopped channel or a sync
        // restarts at phase 0 so the first live cycle is a period start.
        always_comb begin
            w_wr       = w_accept && (cfg_ch == CH_W'(g));
            w_stopped  = (r_div_act == '0);
            w_wrap     = !w_stopped && (r_cnt == (r_div_act - c_one));
            w_cnt_nxt  = (w_wrap || w_stopped || sync) ? '0 : (r_cnt + c_one);
            w_apply    = r_pending && (sync || (en && (w_stopped || w_wrap)));
            w_div_new  = w_apply ? r_div_shd  : r_div_act;
            w_high_new = w_apply ? r_high_shd : r_high_act;
            w_live     = (w_div_new != '0);
        end

        // Channel state: shadow capture, boundary apply, counter and outputs.
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_cnt      <= '0;
                r_div_act  <= c_reset_div;
                r_high_act <= c_reset_high;
                r_div_shd  <= c_reset_div;
                r_high_shd <= c_reset_high;
                r_pending  <= 1'b0;
                r_clk_out  <= c_reset_clk;
                r_tick     <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_div_shd  <= cfg_div;
                    r_high_shd <= cfg_high;
                end
                if (w_apply) begin
                    r_pending <= 1'b0;
                end else if (w_wr) begin
                    r_pending <= 1'b1;
                end
                if (sync || en) begin
                    r_div_act  <= w_div_new;
                    r_high_act <= w_high_new;
                    if (w_live) begin
                        r_cnt     <= w_cnt_nxt;
                        r_clk_out <= (w_cnt_nxt < w_high_new);
                        r_tick    <= (w_cnt_nxt == '0);
                    end else begin
                        r_cnt     <= '0;
                        r_clk_out <= 1'b0;
                        r_tick    <= 1'b0;
                    end
                end else begin
                    r_tick <= 1'b0;
                end
            end
        end

        assign w_pending[g] = r_pending;
        assign clk_out[g]   = r_clk_out;
        assign tick[g]      = r_tick;
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_div_prog
//  Brief    : Self-checking bench for clk_div_prog (4 channels, 8-bit counts,
//             reset setting 16/8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       sync;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [7:0] cfg_high;
    logic [3:0] clk_out;
    logic [3:0] tick;

    int checks = 0;
    int errors = 0;

    // Expected-waveform description per channel: period, high time and the
    // cycle index at which the current period started.
    int m_div  [4];
    int m_high [4];
    int m_base [4];
    bit m_pend [4];
    int p_div  [4];
    int p_high [4];
    int p_at   [4];

    typedef struct {
        int first;
        int last;
        int ch;
        int dv;
        int hi;
        int apply;
    } wr_t;

    typedef struct {
        logic       en;
        logic       v;
        logic [7:0] dv;
        logic [7:0] hi;
        logic       clk0;
        logic       tick0;
        logic       rdy;
    } vec_t;

    wr_t  wr [5];
    vec_t tv [14];

    always #5 clk = ~clk;

    clk_div_prog #(
        .NUM_CH     (4),
        .CNT_WIDTH  (8),
        .RESET_DIV  (16),
        .RESET_HIGH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_clk(input int k);
        logic [3:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) v[c] = (((k - m_base[c]) % m_div[c]) < m_high[c]);
        return v;
    endfunction

    function automatic logic [3:0] exp_tick(input int k);
        logic [3:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) v[c] = (((k - m_base[c]) % m_div[c]) == 0);
        return v;
    endfunction

    initial begin
        int wi;

        // Config writes: drive window [first,last], channel, div, high, and
        // the hand-derived edge where the setting takes effect.
        wr[0] = '{36, 36, 1,  5,  2, 48};
        wr[1] = '{50, 50, 3, 10,  0, 64};
        wr[2] = '{52, 52, 2,  3,  1, 64};
        wr[3] = '{53, 65, 2,  6,  3, 67};
        wr[4] = '{70, 70, 3, 10, 20, 74};

        // Channel 0 corner cases, edges 91..104: div=1 then div=0, with en gaps.
        tv[0]  = '{1'b1, 1'b1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
        tv[3]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
        tv[4]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1};
        tv[6]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1};
        tv[7]  = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1};
        tv[8]  = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 1'b1};
        tv[9]  = '{1'b1, 1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 1'b0};
        tv[10] = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0};
        tv[11] = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1};
        tv[12] = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1};
        tv[13] = '{1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1};

        for (int c = 0; c < 4; c++) begin
            m_div[c]  = 16;
            m_high[c] = 8;
            m_base[c] = 0;
            m_pend[c] = 1'b0;
        end

        // Reset state
        rst = 1'b0; en = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
        cfg_ch = 2'd0; cfg_div = 8'd0; cfg_high = 8'd0;
        step();
        step();
        chk("reset_clk_out", clk_out, 4'hF);
        chk("reset_tick", tick, 4'h0);
        chk("reset_ready", cfg_ready, 1'b1);

        // Default running, mid-period reconfig, high=0 / high>=div, stalled write
        rst = 1'b1;
        en  = 1'b1;
        for (int k = 1; k <= 90; k++) begin
            wi = -1;
            cfg_valid = 1'b0;
            for (int i = 0; i < 5; i++)
                if (k >= wr[i].first && k <= wr[i].last) wi = i;
            if (wi >= 0) begin
                cfg_valid = 1'b1;
                cfg_ch    = 2'(wr[wi].ch);
                cfg_div   = 8'(wr[wi].dv);
                cfg_high  = 8'(wr[wi].hi);
                #1;
                chk($sformatf("ready_k%0d", k), cfg_ready, !m_pend[wr[wi].ch]);
            end
            step();
            if (wi >= 0 && !m_pend[wr[wi].ch]) begin
                m_pend[wr[wi].ch] = 1'b1;
                p_div[wr[wi].ch]  = wr[wi].dv;
                p_high[wr[wi].ch] = wr[wi].hi;
                p_at[wr[wi].ch]   = wr[wi].apply;
            end
            for (int c = 0; c < 4; c++) begin
                if (m_pend[c] && p_at[c] == k) begin
                    m_div[c]  = p_div[c];
                    m_high[c] = p_high[c];
                    m_base[c] = k;
                    m_pend[c] = 1'b0;
                end
            end
            chk($sformatf("clk_out_k%0d", k), clk_out, exp_clk(k));
            chk($sformatf("tick_k%0d", k), tick, exp_tick(k));
        end

        // Channel 0 table: div=1 steady high with tick every enabled cycle,
        // then div=0 stops it; en gaps hold the output and defer the apply.
        cfg_ch = 2'd0;
        for (int r = 0; r < 14; r++) begin
            en        = tv[r].en;
            cfg_valid = tv[r].v;
            cfg_div   = tv[r].dv;
            cfg_high  = tv[r].hi;
            step();
            chk($sformatf("tbl%0d_clk0", r), clk_out[0], tv[r].clk0);
            chk($sformatf("tbl%0d_tick0", r), tick[0], tv[r].tick0);
            chk($sformatf("tbl%0d_ready", r), cfg_ready, tv[r].rdy);
        end

        // Queue 3/4/6 on channels 1..3, then sync with en low: immediate apply
        en = 1'b1; cfg_valid = 1'b1;
        cfg_ch = 2'd1; cfg_div = 8'd3; cfg_high = 8'd1; #1;
        chk("pre_sync_ready1", cfg_ready, 1'b1);
        step();
        cfg_ch = 2'd2; cfg_div = 8'd4; cfg_high = 8'd2; #1;
        chk("pre_sync_ready2", cfg_ready, 1'b1);
        step();
        cfg_ch = 2'd3; cfg_div = 8'd6; cfg_high = 8'd3; #1;
        chk("pre_sync_ready3", cfg_ready, 1'b1);
        step();
        cfg_valid = 1'b0; en = 1'b0; sync = 1'b1;
        step();
        chk("sync_clk_out", clk_out, 4'b1110);
        chk("sync_tick", tick, 4'b1110);
        sync = 1'b0; en = 1'b1;
        step();
        chk("sync_p1_clk", clk_out, 4'b1100);
        chk("sync_p1_tick", tick, 4'b0000);
        step();
        chk("sync_p2_clk", clk_out, 4'b1000);
        chk("sync_p2_tick", tick, 4'b0000);
        step();
        chk("sync_p3_clk", clk_out, 4'b0010);
        chk("sync_p3_tick", tick, 4'b0010);

        // Freeze with en low for 5 cycles
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("frozen%0d_clk", i), clk_out, 4'b0010);
            chk($sformatf("frozen%0d_tick", i), tick, 4'b0000);
        end
        en = 1'b1;
        step();
        chk("resume1_clk", clk_out, 4'b0100);
        chk("resume1_tick", tick, 4'b0100);
        step();
        chk("resume2_clk", clk_out, 4'b0100);
        chk("resume2_tick", tick, 4'b0000);

        // Mid-period reset with a concurrent config write that must be dropped
        rst = 1'b0; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd1; cfg_high = 8'd1;
        step();
        chk("midrst_clk_out", clk_out, 4'hF);
        chk("midrst_tick", tick, 4'h0);
        chk("midrst_ready", cfg_ready, 1'b1);
        rst = 1'b1; cfg_valid = 1'b0;
        for (int j = 1; j <= 18; j++) begin
            step();
            chk($sformatf("post_rst_clk_j%0d", j), clk_out, ((j % 16) < 8) ? 4'hF : 4'h0);
            chk($sformatf("post_rst_tick_j%0d", j), tick, ((j % 16) == 0) ? 4'hF : 4'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
